cargo_shaft_model: RTL and testbench



---
 rtl/cargo_shaft_model.sv | 172 +++++++++++++++++
 tb/tb_cargo_shaft_model.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cargo_shaft_model.sv
// cargo_shaft_model: behavioural plant model of the SmartCargo shaft and cabin.
//
// Takes the controller's final motor commands, integrates the cabin position
// and produces the active-low floor sensor bus that feeds the controller's
// sensoresNeg input. Used for closed-loop simulation and as an on-FPGA stand-in
// when no physical rig is attached.
//
// Ports:
//   clock            system clock
//   reset            synchronous, active-high
//   motorSubindo     up command
//   motorDescendo    down command
//   falha_travamento mechanical stall; position frozen while high
//   sensoresNeg      floor sensors, active-low, bit i = floor i (registered)
//   posicao          cabin position, floor i sits at i*T
//   andar_proximo    nearest floor index
//   em_movimento     position changed on the last edge
//   fim_curso_sup    cabin at top limit
//   fim_curso_inf    cabin at bottom limit
//   erro_motor       both commands high (braking state)
//   erro_sticky      braking state seen since reset
//
// Optional feature macro: CARGO_SHAFT_GLITCH_EN adds LFSR-driven sensor bounce
// for the first 4 cycles after the cabin enters a sensor zone.
module cargo_shaft_model #(
  parameter int unsigned N_ANDARES         = 4,
  parameter int unsigned LOG2_CICLOS_ANDAR = 6,
  parameter int unsigned JANELA_SENSOR     = 4,
  parameter int unsigned ANDAR_INICIAL     = 0,
  localparam int unsigned T       = 1 << LOG2_CICLOS_ANDAR,
  localparam int unsigned POS_MAX = (N_ANDARES - 1) * T,
  localparam int unsigned PW      = $clog2(POS_MAX + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 motorSubindo,
  input  logic                 motorDescendo,
  input  logic                 falha_travamento,
  output logic [N_ANDARES-1:0] sensoresNeg,
  output logic [PW-1:0]        posicao,
  output logic [3:0]           andar_proximo,
  output logic                 em_movimento,
  output logic                 fim_curso_sup,
  output logic                 fim_curso_inf,
  output logic                 erro_motor,
  output logic                 erro_sticky
);

  localparam logic [PW-1:0] PosMaxP  = PW'(POS_MAX);
  localparam logic [PW-1:0] PosIniP  = PW'(ANDAR_INICIAL * T);
  localparam int unsigned   NearMax  = N_ANDARES - 1;

  typedef enum logic [1:0] {StParado, StSubindo, StDescendo, StFrenando} state_e;

  state_e                 r_state, w_state_d;
  logic [PW-1:0]          r_pos, w_pos_d;
  logic [N_ANDARES-1:0]   r_sens, w_sens_clean, w_sens_d;
  logic                   r_mov;
  logic                   r_sticky;
  int unsigned            w_near;

  // Active-low zone decode: bit i low iff |pos - i*T| <= JANELA_SENSOR.
  // Written as two one-sided compares so nothing underflows near floor 0.
  function automatic logic [N_ANDARES-1:0] sensor_clean(input logic [PW-1:0] pos);
    int unsigned p;
    p = 32'(pos);
    for (int unsigned i = 0; i < N_ANDARES; i++) begin
      sensor_clean[i] = 1'b1;
      if ((p + JANELA_SENSOR >= i * T) && (p <= i * T + JANELA_SENSOR)) begin
        sensor_clean[i] = 1'b0;
      end
    end
  endfunction

  assign w_sens_clean = sensor_clean(r_pos);

  // Next state is a pure decode of the commands; motion uses the registered
  // state, giving one cycle of latency from command to first movement.
  always_comb begin
    w_state_d = StParado;
    case ({motorSubindo, motorDescendo})
      2'b10:   w_state_d = StSubindo;
      2'b01:   w_state_d = StDescendo;
      2'b11:   w_state_d = StFrenando;
      default: w_state_d = StParado;
    endcase
  end

  always_comb begin
    w_pos_d = r_pos;
    case (r_state)
      StSubindo: begin
        if ((r_pos != PosMaxP) && !falha_travamento) w_pos_d = r_pos + 1'b1;
      end
      StDescendo: begin
        if ((r_pos != '0) && !falha_travamento) w_pos_d = r_pos - 1'b1;
      end
      default: w_pos_d = r_pos;
    endcase
  end

`ifdef CARGO_SHAFT_GLITCH_EN
  logic [7:0] r_lfsr;
  logic       r_in_zone;
  logic [2:0] r_bounce_cnt;
  logic       w_in_zone;
  logic       w_enter;
  logic       w_bounce;
  logic       w_lfsr_fb;

  assign w_in_zone = ~&w_sens_clean;
  assign w_enter   = w_in_zone & ~r_in_zone;
  // Entry cycle plus three more cycles of bounce.
  assign w_bounce  = w_in_zone & (w_enter | (r_bounce_cnt != 3'd0));
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  // Only the active (low) bit is disturbed.
  assign w_sens_d  = w_bounce ? (w_sens_clean ^ (~w_sens_clean & {N_ANDARES{r_lfsr[0]}}))
                              : w_sens_clean;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr       <= 8'hA5;
      r_in_zone    <= 1'b1;
      r_bounce_cnt <= 3'd0;
    end else begin
      r_lfsr    <= {r_lfsr[6:0], w_lfsr_fb};
      r_in_zone <= w_in_zone;
      if (w_enter) begin
        r_bounce_cnt <= 3'd3;
      end else if (w_in_zone && (r_bounce_cnt != 3'd0)) begin
        r_bounce_cnt <= r_bounce_cnt - 3'd1;
      end else if (!w_in_zone) begin
        r_bounce_cnt <= 3'd0;
      end
    end
  end
`else
  assign w_sens_d = w_sens_clean;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= StParado;
      r_pos    <= PosIniP;
      r_sens   <= sensor_clean(PosIniP);
      r_mov    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_pos    <= w_pos_d;
      r_sens   <= w_sens_d;
      r_mov    <= (w_pos_d != r_pos);
      // Set together with the state so both flags rise on the same edge.
      r_sticky <= r_sticky | (w_state_d == StFrenando);
    end
  end

  always_comb begin
    w_near = (32'(r_pos) + T / 2) >> LOG2_CICLOS_ANDAR;
    if (w_near > NearMax) w_near = NearMax;
  end

  assign sensoresNeg   = r_sens;
  assign posicao       = r_pos;
  assign andar_proximo = 4'(w_near);
  assign em_movimento  = r_mov;
  assign fim_curso_sup = (r_pos == PosMaxP);
  assign fim_curso_inf = (r_pos == '0);
  assign erro_motor    = (r_state == StFrenando);
  assign erro_sticky   = r_sticky;

endmodule

// File: tb/tb_cargo_shaft_model.sv
module tb_cargo_shaft_model;

  localparam int N    = 4;
  localparam int LG   = 6;
  localparam int J    = 4;
  localparam int INI  = 0;
  localparam int T    = 1 << LG;
  localparam int PMAX = (N - 1) * T;
  localparam int PW   = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          su = 1'b0;
  logic          de = 1'b0;
  logic          fa = 1'b0;
  logic [N-1:0]  sensoresNeg;
  logic [PW-1:0] posicao;
  logic [3:0]    andar_proximo;
  logic          em_movimento, fim_curso_sup, fim_curso_inf, erro_motor, erro_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: last command pair, cabin position, lagged sensor image.
  int m_pos = INI * T;
  int m_cmd = 0;
  int m_sens = 0;
  int m_mov = 0;
  int m_sticky = 0;

  cargo_shaft_model #(
    .N_ANDARES        (N),
    .LOG2_CICLOS_ANDAR(LG),
    .JANELA_SENSOR    (J),
    .ANDAR_INICIAL    (INI)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .motorSubindo    (su),
    .motorDescendo   (de),
    .falha_travamento(fa),
    .sensoresNeg     (sensoresNeg),
    .posicao         (posicao),
    .andar_proximo   (andar_proximo),
    .em_movimento    (em_movimento),
    .fim_curso_sup   (fim_curso_sup),
    .fim_curso_inf   (fim_curso_inf),
    .erro_motor      (erro_motor),
    .erro_sticky     (erro_sticky)
  );

  always #5 clock = ~clock;

  function automatic int zone(input int p);
    int r;
    r = (1 << N) - 1;
    for (int i = 0; i < N; i++) begin
      int d;
      d = p - i * T;
      if (d >= -J && d <= J) r = r & ~(1 << i);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    int near;
    near = (m_pos + T / 2) / T;
    if (near > N - 1) near = N - 1;
    chk("posicao", 32'(posicao), m_pos);
    chk("sensoresNeg", 32'(sensoresNeg), m_sens);
    chk("andar_proximo", 32'(andar_proximo), near);
    chk("fim_curso_sup", 32'(fim_curso_sup), (m_pos == PMAX) ? 1 : 0);
    chk("fim_curso_inf", 32'(fim_curso_inf), (m_pos == 0) ? 1 : 0);
    chk("em_movimento", 32'(em_movimento), m_mov);
    chk("erro_motor", 32'(erro_motor), (m_cmd == 3) ? 1 : 0);
    chk("erro_sticky", 32'(erro_sticky), m_sticky);
  endtask

  // Apply one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input logic r, input logic s, input logic d, input logic f);
    int np;
    reset = r; su = s; de = d; fa = f;
    @(posedge clock);
    #1;
    if (r) begin
      m_pos = INI * T; m_cmd = 0; m_sens = zone(INI * T); m_mov = 0; m_sticky = 0;
    end else begin
      np = m_pos;
      if (m_cmd == 2 && m_pos < PMAX && !f) np = m_pos + 1;
      else if (m_cmd == 1 && m_pos > 0 && !f) np = m_pos - 1;
      m_sens = zone(m_pos);
      m_mov  = (np != m_pos) ? 1 : 0;
      m_pos  = np;
      m_cmd  = {30'd0, s, d};
      if (m_cmd == 3) m_sticky = 1;
    end
    compare_model();
  endtask

  typedef struct {
    logic rst, s, d, f;
    int   pos;
    int   sens;
    logic mov, erro, sticky;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int  p0;
    int  cnt;
    logic seen5, seen65;
    logic cs, cd, cf;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 14, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 14, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 14, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 14, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 3, 14, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 14, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 2, 14, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 14, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 14, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 14, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].s, tbl[i].d, tbl[i].f);
      chk("tbl_pos", 32'(posicao), tbl[i].pos);
      chk("tbl_sens", 32'(sensoresNeg), tbl[i].sens);
      chk("tbl_mov", 32'(em_movimento), 32'(tbl[i].mov));
      chk("tbl_erro", 32'(erro_motor), 32'(tbl[i].erro));
      chk("tbl_sticky", 32'(erro_sticky), 32'(tbl[i].sticky));
    end
    chk("reset_inf", 32'(fim_curso_inf), 1);

    // Full climb to the top limit.
    seen5 = 1'b0; seen65 = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (m_pos == 6 && !seen5) begin
        seen5 = 1'b1;
        chk("sensor0_release", 32'(sensoresNeg), 15);
      end
      if (m_pos == 65 && !seen65) begin
        seen65 = 1'b1;
        chk("sensor1_active", 32'(sensoresNeg), 13);
      end
    end
    chk("top_pos", 32'(posicao), PMAX);
    chk("top_sens", 32'(sensoresNeg), 7);
    chk("top_sup", 32'(fim_curso_sup), 1);
    chk("top_mov", 32'(em_movimento), 0);
    chk("top_andar", 32'(andar_proximo), N - 1);

    // Down command held at the bottom.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bottom_pos", 32'(posicao), 0);
    chk("bottom_inf", 32'(fim_curso_inf), 1);
    chk("bottom_mov", 32'(em_movimento), 0);

    // Brake (both commands) while climbing.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    while (m_pos != 100 && cnt < 300) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      cnt++;
    end
    chk("reach_100", 32'(posicao), 100);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    p0 = m_pos;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("brake_hold", 32'(posicao), p0);
      chk("brake_erro", 32'(erro_motor), 1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("brake_release_erro", 32'(erro_motor), 0);
    chk("brake_release_sticky", 32'(erro_sticky), 1);

    // Mechanical stall while climbing.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    while (m_pos != 70 && cnt < 300) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      cnt++;
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk("stall_hold", 32'(posicao), 70);
      chk("stall_mov", 32'(em_movimento), 0);
    end
    chk("stall_sens", 32'(sensoresNeg), 15);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("stall_resume", 32'(posicao), 71);

    // Reset mid-travel.
    cnt = 0;
    while (m_pos != 130 && cnt < 300) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      cnt++;
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("midreset_pos", 32'(posicao), 0);
    chk("midreset_sens", 32'(sensoresNeg), 14);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("midreset_parado", 32'(posicao), 0);

    // Randomised run against the model.
    cs = 1'b0; cd = 1'b0; cf = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 9))
          0, 1:       begin cs = 1'b0; cd = 1'b0; end
          2, 3, 4, 5: begin cs = 1'b1; cd = 1'b0; end
          6, 7, 8:    begin cs = 1'b0; cd = 1'b1; end
          default:    begin cs = 1'b1; cd = 1'b1; end
        endcase
      end
      if ($urandom_range(0, 29) == 0) cf = ~cf;
      step(($urandom_range(0, 399) == 0), cs, cd, cf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
